clarvi_part_sequencer: RTL and testbench
========================================

# clarvi_part_sequencer

Issue stage directly upstream of the Clarvi ALU. It accepts one decoded RV64 instruction with 64-bit operands and splits it into two 32-bit micro-ops (instr_part 0 = low half, 1 = high half). The micro-ops are presented to the ALU in the order the ALU's inter-part carry/compare state requires. The sequencer reassembles the two 32-bit ALU results into a 64-bit writeback value behind a valid/ready handshake.

## Interface
- No parameters; all widths fixed by RV64 on a 32-bit datapath.
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-low
- flush  in  1  abort any in-flight instruction (pipeline redirect)
- in_valid  in  1  decoded instruction available
- in_ready  out  1  sequencer accepts on in_valid && in_ready
- in_instr  in  instr_t  decoded instruction; instr_part field ignored; immediate = low 32 bits of sign-extended immediate
- in_imm_hi  in  32  high 32 bits of sign-extended immediate
- in_rs1  in  64  rs1 value
- in_rs2  in  64  rs2 value
- in_rd  in  5  destination register
- alu_instr  out  instr_t  latched instruction with instr_part and immediate set per part
- alu_rs1  out  32  selected rs1 half
- alu_rs2  out  32  selected rs2 half
- alu_stall  out  1  freezes ALU inter-part state
- alu_result  in  32  combinational ALU result for current part
- out_valid  out  1  64-bit result available
- out_ready  in  1  writeback consumes on out_valid && out_ready
- out_result  out  64  assembled result
- out_rd  out  5  destination of out_result

## Operation
- FSM states: IDLE, FIRST, SECOND.
- Acceptance latches in_instr, in_imm_hi, in_rs1, in_rs2, in_rd; the next state is FIRST.
- high_first = op ∈ {SLT, SLTU, SRL, SRA} && !is32_bit_op.
  - high_first: FIRST issues part 1 and SECOND issues part 0.
  - All other ops, including every is32_bit_op: FIRST issues part 0 and SECOND issues part 1.
- Per part p, selection is: alu_rs1 = rs1 half p; alu_rs2 = rs2 half p; alu_instr.immediate = (p ? imm_hi : imm_lo); alu_instr.instr_part = p. All other instr_t fields pass through unchanged.
- FIRST:
  - alu_stall = 0.
  - alu_result is captured into a 32-bit hold register.
  - The next state is SECOND unconditionally.
- SECOND:
  - If the output register is free (!out_valid || out_ready): alu_stall = 0; out_result = {hi, lo} from the hold register plus alu_result, placed per order; out_rd is loaded; out_valid is set. The next state is IDLE, or FIRST if a new instruction is accepted in the same cycle.
  - If the output register is not free: alu_stall = 1, the micro-op stays on the ALU ports unchanged, and the state remains SECOND.
- IDLE: alu_stall = 1; ALU port values are don't-care.
- in_ready = reset && !flush && (state == IDLE || (state == SECOND && (!out_valid || out_ready))).
- Output register: out_valid clears on out_valid && out_ready unless it is reloaded in the same cycle.
- flush:
  - The next state is IDLE; a FIRST/SECOND op is discarded with no out_valid.
  - An already-valid out_result is kept.
  - No accept occurs in a flush cycle.
- Reset: state IDLE, out_valid 0, out_result 0, out_rd 0, alu_stall 1, in_ready 0 while reset is low.

## Timing
- Accept at edge e0. FIRST occupies e0→e1 and SECOND occupies e1→e2. out_valid is high from e2 if unstalled, a latency of 2 cycles.
- Peak throughput is 1 instruction per 2 cycles; accepting in SECOND gives back-to-back FIRST.
- alu_stall is low at the edge ending FIRST, so the ALU state carries part-A information into part B. While stalled in SECOND, alu_result stays stable because the ALU inputs and state are frozen.
- in_ready, alu_stall and the ALU port values are combinational from state and registers only; there is no in_valid→alu path.
- flush and reset take effect at the next edge and override all other transitions; reset has priority over flush.

## Structure
- The shared riscv package holds instr_t and the op enum, and gains a function is_high_first(instr_t) for reuse by hazard logic.
- One sub-module: clarvi_result_buffer, the 64-bit + rd output register with valid/ready; it exposes a free signal to the FSM.
- Part/half selection is a local function within the sequencer.

## Test plan
- ADD, rs1=0x00000000_FFFFFFFF, rs2=1, out_ready=1 → FIRST instr_part=0, SECOND instr_part=1; out_result=0x00000001_00000000; out_valid 2 edges after accept.
- SLTU, rs1=0x00000001_00000000, rs2=0x00000000_FFFFFFFF → FIRST instr_part=1 with alu_rs1=1, alu_rs2=0; out_result=0.
- ADDW, rs1=0x7FFFFFFF, rs2=1 → order part 0 then part 1; out_result=0xFFFFFFFF_80000000.
- Three back-to-back ADDs, out_ready=0 for 5 cycles, then 1 → second op holds in SECOND with alu_stall=1 and stable alu_result; all three results delivered in order with correct values.
- flush asserted during SECOND → no out_valid for that op; in_ready=0 in the flush cycle; following XOR executes correctly.
- reset low during FIRST → next cycle state IDLE, out_valid=0, out_result=0, alu_stall=1, in_ready=0.

Source files
------------

// File: rtl/clarvi_part_sequencer_pkg.sv
// Shared RISC-V decode types for the 32-bit Clarvi datapath.
// Also holds the part-ordering rule used by the sequencer and hazard logic.
package clarvi_part_sequencer_pkg;

    typedef enum logic [3:0] {
        OP_ADD,
        OP_SUB,
        OP_SLL,
        OP_SLT,
        OP_SLTU,
        OP_XOR,
        OP_SRL,
        OP_SRA,
        OP_OR,
        OP_AND
    } op_t;

    typedef struct packed {
        op_t         op;
        logic        is32_bit_op;
        logic        instr_part;
        logic [31:0] immediate;
    } instr_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FIRST,
        ST_SECOND
    } state_t;

    // Compares and right shifts need the high half resolved first.
    function automatic logic is_high_first(input instr_t i);
        logic hf_op;
        hf_op = (i.op == OP_SLT) || (i.op == OP_SLTU) ||
                (i.op == OP_SRL) || (i.op == OP_SRA);
        return hf_op && !i.is32_bit_op;
    endfunction

endpackage

// File: rtl/clarvi_part_sequencer_result_buffer.sv
// 64-bit result + rd output register with valid/ready handshake.
// free tells the sequencer a new result can be loaded this cycle.
module clarvi_result_buffer (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [63:0] load_result,
    input  logic [4:0]  load_rd,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [63:0] out_result,
    output logic [4:0]  out_rd,
    output logic        free
);

    logic        valid_q, valid_d;
    logic [63:0] result_q, result_d;
    logic [4:0]  rd_q, rd_d;

    always_comb begin
        free     = !valid_q || out_ready;
        valid_d  = valid_q;
        result_d = result_q;
        rd_d     = rd_q;
        if (load) begin
            valid_d  = 1'b1;
            result_d = load_result;
            rd_d     = load_rd;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            rd_q     <= '0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            rd_q     <= rd_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_result = result_q;
    assign out_rd     = rd_q;

endmodule

// File: rtl/clarvi_part_sequencer.sv
// Splits one RV64 op into two 32-bit ALU micro-ops and
// reassembles the halves into a 64-bit writeback result.
module clarvi_part_sequencer
    import clarvi_part_sequencer_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  instr_t      in_instr,
    input  logic [31:0] in_imm_hi,
    input  logic [63:0] in_rs1,
    input  logic [63:0] in_rs2,
    input  logic [4:0]  in_rd,
    output instr_t      alu_instr,
    output logic [31:0] alu_rs1,
    output logic [31:0] alu_rs2,
    output logic        alu_stall,
    input  logic [31:0] alu_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_result,
    output logic [4:0]  out_rd
);

    state_t      state_q, state_d;
    instr_t      instr_q, instr_d;
    logic [31:0] imm_hi_q, imm_hi_d;
    logic [63:0] rs1_q, rs1_d;
    logic [63:0] rs2_q, rs2_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] hold_q, hold_d;

    logic        free;
    logic        accept;
    logic        part;
    logic        load;
    logic [63:0] load_result;

    function automatic logic [31:0] half(input logic [63:0] v, input logic p);
        return p ? v[63:32] : v[31:0];
    endfunction

    always_comb begin
        part = is_high_first(instr_q) ^ (state_q == ST_SECOND);
        alu_instr            = instr_q;
        alu_instr.instr_part = part;
        alu_instr.immediate  = part ? imm_hi_q : instr_q.immediate;
        alu_rs1 = half(rs1_q, part);
        alu_rs2 = half(rs2_q, part);
    end

    always_comb begin
        in_ready = reset && !flush &&
                   (state_q == ST_IDLE || (state_q == ST_SECOND && free));
        accept    = in_valid && in_ready;
        alu_stall = !reset ||
                    !(state_q == ST_FIRST || (state_q == ST_SECOND && free));
        load = reset && !flush && state_q == ST_SECOND && free;
        // The hold register always carries the half issued in FIRST.
        load_result = part ? {alu_result, hold_q} : {hold_q, alu_result};
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   state_d = accept ? ST_FIRST : ST_IDLE;
            ST_FIRST:  state_d = ST_SECOND;
            ST_SECOND: begin
                if (free) state_d = accept ? ST_FIRST : ST_IDLE;
            end
            default:   state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

    always_comb begin
        instr_d  = instr_q;
        imm_hi_d = imm_hi_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        rd_d     = rd_q;
        hold_d   = (state_q == ST_FIRST) ? alu_result : hold_q;
        if (accept) begin
            instr_d  = in_instr;
            imm_hi_d = in_imm_hi;
            rs1_d    = in_rs1;
            rs2_d    = in_rs2;
            rd_d     = in_rd;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            instr_q  <= '0;
            imm_hi_q <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rd_q     <= '0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            imm_hi_q <= imm_hi_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            rd_q     <= rd_d;
            hold_q   <= hold_d;
        end
    end

    clarvi_result_buffer u_buf (
        .clock       (clock),
        .reset       (reset),
        .load        (load),
        .load_result (load_result),
        .load_rd     (rd_q),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_result  (out_result),
        .out_rd      (out_rd),
        .free        (free)
    );

endmodule

// File: tb/tb_clarvi_part_sequencer.sv
// Bench for clarvi_part_sequencer with a small two-part ALU model
// and a result scoreboard.
module tb_clarvi_part_sequencer;
    import clarvi_part_sequencer_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    instr_t      in_instr;
    logic [31:0] in_imm_hi;
    logic [63:0] in_rs1;
    logic [63:0] in_rs2;
    logic [4:0]  in_rd;
    instr_t      alu_instr;
    logic [31:0] alu_rs1;
    logic [31:0] alu_rs2;
    logic        alu_stall;
    logic [31:0] alu_result;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic [4:0]  out_rd;

    int n_cmp = 0;
    int n_bad = 0;
    logic [68:0] sb_q[$];
    logic [68:0] mon_e;

    clarvi_part_sequencer dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_imm_hi  (in_imm_hi),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_rd      (in_rd),
        .alu_instr  (alu_instr),
        .alu_rs1    (alu_rs1),
        .alu_rs2    (alu_rs2),
        .alu_stall  (alu_stall),
        .alu_result (alu_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd)
    );

    always #5 clock = ~clock;

    // ALU model: carry / sign from part 0, compare flags from part 1.
    logic cy_q = 1'b0;
    logic sgn_q = 1'b0;
    logic lt_q = 1'b0;
    logic eq_q = 1'b0;
    logic [32:0] sum33;

    always_comb begin
        alu_result = '0;
        sum33 = {1'b0, alu_rs1} + {1'b0, alu_rs2};
        case (alu_instr.op)
            OP_ADD: begin
                if (!alu_instr.instr_part)
                    alu_result = sum33[31:0];
                else if (alu_instr.is32_bit_op)
                    alu_result = {32{sgn_q}};
                else
                    alu_result = alu_rs1 + alu_rs2 + {31'b0, cy_q};
            end
            OP_SLTU: begin
                if (!alu_instr.instr_part)
                    alu_result = {31'b0, lt_q | (eq_q & (alu_rs1 < alu_rs2))};
            end
            OP_XOR: alu_result = alu_rs1 ^ alu_rs2;
            default: alu_result = '0;
        endcase
    end

    always @(posedge clock) begin
        if (!alu_stall) begin
            if (!alu_instr.instr_part) begin
                cy_q  <= sum33[32];
                sgn_q <= alu_result[31];
            end else begin
                lt_q <= alu_rs1 < alu_rs2;
                eq_q <= alu_rs1 == alu_rs2;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input op_t op, input logic is32,
                         input logic [63:0] r1, input logic [63:0] r2,
                         input logic [4:0] rd, input logic push,
                         input logic [63:0] exp);
        logic acc;
        acc = 1'b0;
        in_valid              = 1'b1;
        in_instr.op           = op;
        in_instr.is32_bit_op  = is32;
        in_instr.instr_part   = 1'b0;
        in_instr.immediate    = '0;
        in_imm_hi             = '0;
        in_rs1                = r1;
        in_rs2                = r2;
        in_rd                 = rd;
        if (push) sb_q.push_back({rd, exp});
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clock);
            acc = in_ready;
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL issue_timeout: rd=%0d not accepted", rd);
        end
    endtask

    always @(negedge clock) begin
        if (reset && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_out: got rd=%0d result=%h required none",
                         out_rd, out_result);
            end else begin
                mon_e = sb_q.pop_front();
                chk("out_result", out_result, mon_e[63:0]);
                chk("out_rd", {59'b0, out_rd}, {59'b0, mon_e[68:64]});
            end
        end
    end

    initial begin
        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_imm_hi = '0;
        in_rs1    = '0;
        in_rs2    = '0;
        in_rd     = '0;
        out_ready = 1'b1;
        step();
        step();
        chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_out_result", out_result, 64'd0);
        chk("rst_out_rd", {59'b0, out_rd}, 64'd0);
        chk("rst_alu_stall", {63'b0, alu_stall}, 64'd1);
        chk("rst_in_ready", {63'b0, in_ready}, 64'd0);
        reset = 1'b1;
        #1;
        chk("idle_in_ready", {63'b0, in_ready}, 64'd1);

        // ADD with carry across halves
        issue(OP_ADD, 1'b0, 64'h00000000_FFFFFFFF, 64'd1, 5'd3, 1'b1,
              64'h00000001_00000000);
        chk("add_first_part", {63'b0, alu_instr.instr_part}, 64'd0);
        chk("add_first_stall", {63'b0, alu_stall}, 64'd0);
        step();
        chk("add_second_part", {63'b0, alu_instr.instr_part}, 64'd1);
        chk("add_e1_valid", {63'b0, out_valid}, 64'd0);
        step();
        chk("add_e2_valid", {63'b0, out_valid}, 64'd1);

        // SLTU runs high half first
        issue(OP_SLTU, 1'b0, 64'h00000001_00000000, 64'h00000000_FFFFFFFF,
              5'd4, 1'b1, 64'd0);
        chk("sltu_first_part", {63'b0, alu_instr.instr_part}, 64'd1);
        chk("sltu_first_rs1", {32'b0, alu_rs1}, 64'd1);
        chk("sltu_first_rs2", {32'b0, alu_rs2}, 64'd0);
        step();
        chk("sltu_second_part", {63'b0, alu_instr.instr_part}, 64'd0);
        step();

        // ADDW runs low half first
        issue(OP_ADD, 1'b1, 64'h00000000_7FFFFFFF, 64'd1, 5'd5, 1'b1,
              64'hFFFFFFFF_80000000);
        chk("addw_first_part", {63'b0, alu_instr.instr_part}, 64'd0);
        step();
        chk("addw_second_part", {63'b0, alu_instr.instr_part}, 64'd1);
        step();
        step();

        // Back-to-back with writeback backpressure
        out_ready = 1'b0;
        issue(OP_ADD, 1'b0, 64'd1, 64'd2, 5'd6, 1'b1, 64'd3);
        issue(OP_ADD, 1'b0, 64'h00000001_FFFFFFFF, 64'd1, 5'd7, 1'b1,
              64'h00000002_00000000);
        fork
            issue(OP_ADD, 1'b0, 64'hFFFFFFFF_FFFFFFFF, 64'd1, 5'd8, 1'b1,
                  64'd0);
            begin
                for (int i = 0; i < 4; i++) begin
                    step();
                    chk("bp_stall", {63'b0, alu_stall}, 64'd1);
                    chk("bp_part", {63'b0, alu_instr.instr_part}, 64'd1);
                    chk("bp_alu_result", {32'b0, alu_result}, 64'd2);
                    chk("bp_in_ready", {63'b0, in_ready}, 64'd0);
                end
                out_ready = 1'b1;
            end
        join
        repeat (4) step();

        // Flush in SECOND drops the op; XOR presented meanwhile
        issue(OP_ADD, 1'b0, 64'd5, 64'd6, 5'd9, 1'b0, 64'd0);
        step();
        in_valid    = 1'b1;
        in_instr.op = OP_XOR;
        in_rs1      = 64'hF0F0F0F0_12345678;
        in_rs2      = 64'h0FF00FF0_FFFF0000;
        in_rd       = 5'd10;
        flush       = 1'b1;
        #1;
        chk("flush_in_ready", {63'b0, in_ready}, 64'd0);
        step();
        flush = 1'b0;
        #1;
        chk("flush_no_valid", {63'b0, out_valid}, 64'd0);
        chk("flush_idle_ready", {63'b0, in_ready}, 64'd1);
        issue(OP_XOR, 1'b0, 64'hF0F0F0F0_12345678, 64'h0FF00FF0_FFFF0000,
              5'd10, 1'b1, 64'hFF00FF00_EDCB5678);
        repeat (4) step();

        // Reset while in FIRST
        issue(OP_ADD, 1'b0, 64'd7, 64'd8, 5'd11, 1'b0, 64'd0);
        reset = 1'b0;
        #1;
        chk("rstlow_in_ready", {63'b0, in_ready}, 64'd0);
        step();
        chk("rst2_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst2_out_result", out_result, 64'd0);
        chk("rst2_out_rd", {59'b0, out_rd}, 64'd0);
        chk("rst2_alu_stall", {63'b0, alu_stall}, 64'd1);
        chk("rst2_in_ready", {63'b0, in_ready}, 64'd0);
        reset = 1'b1;
        #1;
        chk("rst2_idle_ready", {63'b0, in_ready}, 64'd1);
        chk("rst2_idle_stall", {63'b0, alu_stall}, 64'd1);
        repeat (3) step();
        chk("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
